// File: rtl/stack_if.sv
// Command and status bundle between the controller FSM and the operand stack.
// The master modport is the controller side and the slave modport is the stack side.
interface stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, din, clr_err,
        input  tos, nos, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, din, clr_err,
        output tos, nos, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: single-cycle push, pop and replace-top,
// with full/empty status and sticky overflow/underflow flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    stack_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             isEmpty, isFull;
    logic [AW-1:0]    topAddr, nosAddr;
    logic             wrEn;
    logic [AW-1:0]    wrAddr;
    logic             ovfErr, udfErr;

    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == CW'(DEPTH));

    // Low address bits wrap modulo DEPTH, so count==DEPTH still maps the top to DEPTH-1.
    assign topAddr = count_q[AW-1:0] - AW'(1);
    assign nosAddr = count_q[AW-1:0] - AW'(2);

    always_comb begin
        count_d = count_q;
        wrEn    = 1'b0;
        wrAddr  = count_q[AW-1:0];
        ovfErr  = 1'b0;
        udfErr  = 1'b0;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (isFull) begin
                    ovfErr = 1'b1;
                end else begin
                    wrEn    = 1'b1;
                    wrAddr  = count_q[AW-1:0];
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (isEmpty) begin
                    udfErr = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            2'b11: begin
                if (isEmpty) begin
                    udfErr = 1'b1;
                end else begin
                    wrEn   = 1'b1;
                    wrAddr = topAddr;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
        // A fresh error wins over a simultaneous clear of the same flag.
        overflow_d  = (overflow_q  & ~bus.clr_err) | ovfErr;
        underflow_d = (underflow_q & ~bus.clr_err) | udfErr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage is left unreset; stale contents are hidden by the output masking.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrAddr] <= bus.din;
        end
    end

    assign bus.tos       = isEmpty ? '0 : mem_q[topAddr];
    assign bus.nos       = (count_q < CW'(2)) ? '0 : mem_q[nosAddr];
    assign bus.count     = count_q;
    assign bus.empty     = isEmpty;
    assign bus.full      = isFull;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the stack-machine multicycle CPU. It sits between the 32x8 data memory and the ALU. Memory read data, and ALU results routed back by the controller, are pushed through `din`. The top two entries (`tos`, `nos`) feed the ALU operands and the memory write-data path. Push, pop and replace-top are single-cycle operations, with full/empty status and sticky overflow/underflow error flags for the controller FSM.

## Interface
- `WIDTH`, 8: entry width in bits; matches the data memory word.
- `DEPTH`, 8: number of entries; a power of two, at least 2.
- `CW`, $clog2(DEPTH)+1: width of `count`; derived, not overridden.

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: active-low reset. One clock; reset is asynchronous and active-low.
- `push` input 1: push `din` on this edge.
- `pop` input 1: pop the top entry on this edge.
- `din` input WIDTH: data to push or replace; from memory `RD` or the ALU result mux.
- `clr_err` input 1: clears `overflow` and `underflow` on this edge.
- `tos` output WIDTH: top-of-stack entry; 0 when `count`==0.
- `nos` output WIDTH: next-on-stack entry; 0 when `count`<2.
- `count` output CW: number of valid entries, 0..DEPTH.
- `empty` output 1: `count`==0.
- `full` output 1: `count`==DEPTH.
- `overflow` output 1: sticky; set by a push while full.
- `underflow` output 1: sticky; set by a pop or replace while empty.

## Operation
- **Storage:** DEPTH x WIDTH register array plus `count` register. Entry i holds the (i+1)-th pushed value; the top is at index `count`-1.
- **Output decode:** `tos` = array[`count`-1] and `nos` = array[`count`-2] when valid. Both are masked to 0 otherwise. They are combinational decodes of registered state only; no combinational path from any input.
- **Command decode**, sampled at the rising edge:
  - Idle (`push`=0, `pop`=0): no change.
  - Push (`push`=1, `pop`=0):
    - If not full: array[`count`] <= `din`, `count`+1.
    - If full: no state change, `overflow` <= 1.
  - Pop (`push`=0, `pop`=1):
    - If not empty: `count`-1. Array contents are left unchanged.
    - If empty: no state change, `underflow` <= 1.
  - Replace (`push`=1, `pop`=1):
    - If not empty: array[`count`-1] <= `din`, `count` unchanged. This is used to write back an ALU result over the remaining operand.
    - If empty: no state change, `underflow` <= 1.
    - Replace while full is legal; it does not set `overflow`.
- **Error flags:**
  - Sticky until `clr_err`. `clr_err` clears both flags.
  - If `clr_err` coincides with a new error, the new error's flag ends the cycle at 1; the other flag clears.
- **Arithmetic:** `count` never wraps. Guarded operations are the only way it changes, so it stays within 0..DEPTH.
- **Reset** (asynchronous, `rst_n`=0):
  - `count`=0, `overflow`=0, `underflow`=0.
  - As a result: `empty`=1, `full`=0, `tos`=0, `nos`=0.
  - Array contents are not reset; they are unobservable because of the output masking.

## Timing
- All state updates occur on the rising `clk` edge. Results are visible on `tos`/`nos`/`count`/`full`/`empty`/flags after that edge, i.e. one-cycle latency from command to output.
- No handshake: a command is accepted every cycle. The controller must issue at most one command per cycle and hold it for exactly one cycle per intended operation.
- Reset assertion clears state immediately, without a clock edge, including in the middle of a command. Deassertion is expected synchronous to `clk` (the upstream reset synchroniser guarantees this). The first edge after deassertion executes normally.
- Back-to-back pops, pushes and replaces are all full rate. A pop followed by a replace implements a binary ALU op in two cycles.

## Test plan
- **Reset defaults:** assert `rst_n`=0 for 2 cycles, then release → `count`=0, `empty`=1, `full`=0, `tos`=0, `nos`=0, both flags 0.
- **Push/pop order:** push 0x11, 0x22, 0x33 → `count`=3, `tos`=0x33, `nos`=0x22. Pop twice → `tos`=0x11, `nos`=0, `count`=1.
- **Overflow:** push 8 values 0x01..0x08 → `full`=1, `tos`=0x08. A ninth push of 0xFF → `overflow`=1, `count`=8, `tos`=0x08.
- **Underflow and replace:**
  - Pop on empty → `underflow`=1, `count`=0.
  - Replace on empty → still `underflow`=1, `count`=0.
  - Push 0x05, then replace with 0x0A → `tos`=0x0A, `count`=1.
  - With the stack full, replace → `overflow` unchanged.
- **Error clear vs new error:** with both flags set, `clr_err`=1 together with a pop on empty → `underflow`=1, `overflow`=0. Then `clr_err` alone → both 0.
- **Async reset mid-operation:** with `count`=3, drop `rst_n` between clock edges while `push`=1 → `count`=0 and `tos`=0 before the next edge; no push is recorded after release.
